tlp_axi4_wr_master: RTL and testbench

TLP_AXI4_WR_MASTER -- requirements
Module: tlp_axi4_wr_master

---
 rtl/tlp_wr_pkg.sv | 30 +++
 rtl/tlp_wr_if.sv | 31 +++
 rtl/tlp_axi4_wr_master.sv | 151 +++++++++++++++
 tb/tb_tlp_axi4_wr_master.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_wr_pkg.sv
// Shared definitions for the TLP-to-AXI4 write master.
// Holds the FSM state type, the fixed AXI encodings used on the AW/B
// channels, the number of dwords per data beat and the helper that builds
// the byte-strobe for a partially filled final beat.
package tlp_wr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W,
    B
  } state_e;

  localparam logic [2:0] AXSIZE_32B  = 3'd5;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         DW_PER_BEAT = 8;

  // Byte strobe for a beat carrying 'rem' valid dwords (1..DW_PER_BEAT),
  // packed from DW0 upward.
  function automatic logic [DW_PER_BEAT*4-1:0] strb_for_rem(input logic [3:0] rem);
    logic [DW_PER_BEAT*4-1:0] s;
    s = '0;
    for (int i = 0; i < DW_PER_BEAT * 4; i++) begin
      if (i < 4 * int'(rem)) s[i] = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/tlp_wr_if.sv
// AXI4 write-address and write-data channel bundles.
// AXI4_A_IF : avalid/aready handshake with aid, aaddr, alen, asize, aburst.
// AXI4_W_IF : wvalid/wready handshake with wdata, wstrb, wlast.
interface AXI4_A_IF #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
);
  logic                  avalid;
  logic                  aready;
  logic [ID_WIDTH-1:0]   aid;
  logic [ADDR_WIDTH-1:0] aaddr;
  logic [7:0]            alen;
  logic [2:0]            asize;
  logic [1:0]            aburst;

  modport master (output avalid, aid, aaddr, alen, asize, aburst, input aready);
  modport slave  (input avalid, aid, aaddr, alen, asize, aburst, output aready);
endinterface

interface AXI4_W_IF #(
  parameter int DATA_WIDTH = 256
);
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  modport master (output wvalid, wdata, wstrb, wlast, input wready);
  modport slave  (input wvalid, wdata, wstrb, wlast, output wready);
endinterface

// File: rtl/tlp_axi4_wr_master.sv
// Converts a single MemWr TLP (header + payload beats) into one AXI4 INCR
// write burst and waits for its write response.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   hdr_valid/hdr_ready        TLP header handshake (addr, length, bdf, is_memwrite)
//   data_valid/data_ready/data payload beats, DW0 in bits [31:0]
//   m_axi_aw, m_axi_w          AXI4 write-address / write-data master channels
//   bvalid/bready/bresp/bid    AXI4 write-response channel
//   done                       one-cycle pulse after each completed write
//   err_cnt                    saturating count of dropped or errored requests
module tlp_axi4_wr_master
  import tlp_wr_pkg::*;
#(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 256,
  parameter int CHUNK_MAX_BEATS = 4,
  parameter int AXI_ID          = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hdr_valid,
  output logic                  hdr_ready,
  input  logic [ADDR_WIDTH-1:0] hdr_addr,
  input  logic [9:0]            hdr_length,
  input  logic [15:0]           hdr_bdf,
  input  logic                  hdr_is_memwrite,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] data,
  AXI4_A_IF.master              m_axi_aw,
  AXI4_W_IF.master              m_axi_w,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  input  logic [ID_WIDTH-1:0]   bid,
  output logic                  done,
  output logic [7:0]            err_cnt
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [5:0]            len_q;
  logic [2:0]            beats_q;
  logic [2:0]            beat_cnt;
  logic [15:0]           dbg_bdf;

  logic                  hdr_accept;
  logic                  hdr_legal;
  logic [2:0]            beats_calc;
  logic [3:0]            last_rem;
  logic                  w_fire;
  logic                  err_inc;
  logic                  unused_inputs;

  assign hdr_accept = hdr_valid && hdr_ready;
  assign hdr_legal  = hdr_is_memwrite && (hdr_length != 10'd0) &&
                      (hdr_length <= 10'(CHUNK_MAX_BEATS * DW_PER_BEAT));
  // Only evaluated for legal lengths (<= 32), so 6 bits cannot overflow.
  assign beats_calc = 3'((hdr_length[5:0] + 6'd7) >> 3);
  // Dwords carried by the final beat: 1..DW_PER_BEAT.
  assign last_rem   = 4'(len_q - {beats_q - 3'd1, 3'b000});
  assign w_fire     = (state_q == W) && data_valid && m_axi_w.wready;

  // Address fields only change on header accept, so they are stable for the
  // whole time avalid is high.
  assign m_axi_aw.aid    = ID_WIDTH'(AXI_ID);
  assign m_axi_aw.aaddr  = addr_q;
  assign m_axi_aw.alen   = {5'b00000, beats_q - 3'd1};
  assign m_axi_aw.asize  = AXSIZE_32B;
  assign m_axi_aw.aburst = BURST_INCR;
  assign m_axi_w.wdata   = data;

  // Address low bits, response ID and the latched BDF are intentionally not
  // used by the datapath.
  assign unused_inputs = ^{hdr_addr[4:0], bid, dbg_bdf};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and channel controls; W is a pure combinational passthrough
  // so back-to-back beats need no bubbles.
  always_comb begin
    state_d         = state_q;
    hdr_ready       = 1'b0;
    data_ready      = 1'b0;
    bready          = 1'b0;
    err_inc         = 1'b0;
    m_axi_aw.avalid = 1'b0;
    m_axi_w.wvalid  = 1'b0;
    m_axi_w.wlast   = 1'b0;
    m_axi_w.wstrb   = '1;
    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted so nothing is offered until release.
        hdr_ready = rst_n;
        if (hdr_valid && rst_n) begin
          if (hdr_legal) state_d = AW;
          else           err_inc = 1'b1;
        end
      end
      AW: begin
        m_axi_aw.avalid = 1'b1;
        if (m_axi_aw.aready) state_d = W;
      end
      W: begin
        m_axi_w.wvalid = data_valid;
        data_ready     = m_axi_w.wready;
        m_axi_w.wlast  = (beat_cnt == beats_q - 3'd1);
        if (m_axi_w.wlast) m_axi_w.wstrb = strb_for_rem(last_rem);
        if (w_fire && m_axi_w.wlast) state_d = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) begin
          state_d = IDLE;
          if (bresp != RESP_OKAY) err_inc = 1'b1;
        end
      end
    endcase
  end

  // Header latch, beat counter, completion pulse and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      beat_cnt <= '0;
      dbg_bdf  <= '0;
      done     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      done <= (state_q == B) && bvalid;
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (hdr_accept && hdr_legal) begin
        addr_q   <= {hdr_addr[ADDR_WIDTH-1:5], 5'b00000};
        len_q    <= hdr_length[5:0];
        beats_q  <= beats_calc;
        beat_cnt <= '0;
        dbg_bdf  <= hdr_bdf;
      end else if (w_fire) begin
        beat_cnt <= beat_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_tlp_axi4_wr_master.sv
// Scoreboard bench for tlp_axi4_wr_master: the stimulus task pushes the
// hand-computed AW/W/done expectations, and an independent negedge monitor
// pops and compares them whenever the DUT presents a transfer.
module tb_tlp_axi4_wr_master;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 256;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  hdr_valid;
  logic                  hdr_ready;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic [9:0]            hdr_length;
  logic [15:0]           hdr_bdf;
  logic                  hdr_is_memwrite;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic [ID_WIDTH-1:0]   bid;
  logic                  done;
  logic [7:0]            err_cnt;

  AXI4_A_IF #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) aw_if ();
  AXI4_W_IF #(.DATA_WIDTH(DATA_WIDTH)) w_if ();

  tlp_axi4_wr_master #(
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .CHUNK_MAX_BEATS(4), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_addr(hdr_addr),
    .hdr_length(hdr_length), .hdr_bdf(hdr_bdf), .hdr_is_memwrite(hdr_is_memwrite),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .m_axi_aw(aw_if), .m_axi_w(w_if),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_exp_t;

  typedef struct packed {
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         wlast;
  } w_exp_t;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];
  int      pending_done = 0;
  int      exp_err = 0;
  int      n_checks = 0;
  int      n_pass = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Every dword of every beat is unique so ordering and duplication show up.
  function automatic logic [255:0] beat_data(input int tag, input int k);
    logic [255:0] v;
    for (int d = 0; d < 8; d++) v[32*d +: 32] = {8'(tag), 8'(k), 8'(d), 8'h5A};
    return v;
  endfunction

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  // exp_beats == 0 marks a header the DUT must drop.
  task automatic applyStimulus(input int tag, input logic [31:0] addr, input logic [9:0] len,
                               input logic memwr, input logic [31:0] exp_awaddr,
                               input int exp_beats, input logic [31:0] exp_last_strb,
                               input logic [1:0] resp, input logic [3:0] wpat,
                               input int aw_delay, input int reset_after);
    int t;
    int pidx;
    int wcyc;
    logic got;
    w_exp_t we;
    if (exp_beats > 0) begin
      aw_q.push_back('{addr: exp_awaddr, len: 8'(exp_beats - 1)});
      for (int k = 0; k < exp_beats; k++) begin
        we.wdata = beat_data(tag, k);
        we.wlast = (k == exp_beats - 1);
        we.wstrb = we.wlast ? exp_last_strb : 32'hFFFF_FFFF;
        w_q.push_back(we);
      end
      if (reset_after < 0) begin
        pending_done++;
        if (resp != 2'b00) bump_err();
      end
    end else begin
      bump_err();
    end

    hdr_addr = addr; hdr_length = len; hdr_is_memwrite = memwr;
    hdr_bdf = 16'(tag); hdr_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!hdr_ready && t < 50) begin @(negedge clk); t++; end
    checkOutput("hdr_accept", 256'(hdr_ready), 256'(1));
    @(posedge clk); #1;
    hdr_valid = 1'b0;

    if (exp_beats == 0) begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("err_cnt_drop", 256'(err_cnt), 256'(exp_err));
      return;
    end

    aw_if.aready = (aw_delay == 0);
    @(negedge clk);
    checkOutput("aw_latency", 256'(aw_if.avalid), 256'(1));
    t = 0;
    while (!(aw_if.avalid && aw_if.aready) && t < 50) begin
      @(posedge clk); #1;
      t++;
      if (t >= aw_delay) aw_if.aready = 1'b1;
      @(negedge clk);
    end
    checkOutput("aw_handshake", 256'(aw_if.avalid && aw_if.aready), 256'(1));
    @(posedge clk); #1;
    aw_if.aready = 1'b0;

    pidx = 0;
    wcyc = 0;
    for (int k = 0; k < exp_beats; k++) begin
      data = beat_data(tag, k);
      data_valid = 1'b1;
      got = 1'b0;
      t = 0;
      while (!got && t < 50) begin
        w_if.wready = wpat[pidx];
        pidx = (pidx + 1) % 4;
        @(negedge clk);
        wcyc++; t++;
        got = data_ready && data_valid;
        @(posedge clk); #1;
      end
      checkOutput("w_beat_accept", 256'(got), 256'(1));
      if (k + 1 == reset_after) begin
        data_valid = 1'b0;
        w_if.wready = 1'b0;
        w_q.delete();
        pending_done = 0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_avalid", 256'(aw_if.avalid), 256'(0));
        checkOutput("rst_wvalid", 256'(w_if.wvalid), 256'(0));
        checkOutput("rst_wlast", 256'(w_if.wlast), 256'(0));
        checkOutput("rst_data_ready", 256'(data_ready), 256'(0));
        checkOutput("rst_hdr_ready", 256'(hdr_ready), 256'(0));
        checkOutput("rst_bready", 256'(bready), 256'(0));
        checkOutput("rst_done", 256'(done), 256'(0));
        checkOutput("rst_err_cnt", 256'(err_cnt), 256'(0));
        exp_err = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_release_hdr_ready", 256'(hdr_ready), 256'(1));
        checkOutput("rst_no_replay", 256'(aw_if.avalid), 256'(0));
        @(posedge clk); #1;
        return;
      end
    end
    data_valid = 1'b0;
    w_if.wready = 1'b0;
    if (wpat == 4'b1111) checkOutput("w_no_bubble", 256'(wcyc), 256'(exp_beats));

    bvalid = 1'b1; bresp = resp; bid = '0;
    t = 0;
    @(negedge clk);
    while (!bready && t < 50) begin @(negedge clk); t++; end
    checkOutput("b_handshake", 256'(bready), 256'(1));
    @(posedge clk); #1;
    bvalid = 1'b0; bresp = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("err_cnt", 256'(err_cnt), 256'(exp_err));
    checkOutput("aw_drained", 256'(aw_q.size()), 256'(0));
    checkOutput("w_drained", 256'(w_q.size()), 256'(0));
    checkOutput("done_seen", 256'(pending_done), 256'(0));
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (aw_if.avalid) begin
        checkOutput("aw_hdr_ready_low", 256'(hdr_ready), 256'(0));
        checkOutput("aw_data_ready_low", 256'(data_ready), 256'(0));
        checkOutput("aw_expected", 256'(aw_q.size() > 0), 256'(1));
        if (aw_q.size() > 0) begin
          checkOutput("awaddr", 256'(aw_if.aaddr), 256'(aw_q[0].addr));
          checkOutput("awlen", 256'(aw_if.alen), 256'(aw_q[0].len));
          checkOutput("awsize", 256'(aw_if.asize), 256'(3'd5));
          checkOutput("awburst", 256'(aw_if.aburst), 256'(2'b01));
          checkOutput("awid", 256'(aw_if.aid), 256'(0));
          if (aw_if.aready) void'(aw_q.pop_front());
        end
      end
      if (w_if.wvalid) begin
        checkOutput("data_ready_mirror", 256'(data_ready), 256'(w_if.wready));
        if (w_if.wready) begin
          checkOutput("w_expected", 256'(w_q.size() > 0), 256'(1));
          if (w_q.size() > 0) begin
            checkOutput("wdata", w_if.wdata, w_q[0].wdata);
            checkOutput("wstrb", 256'(w_if.wstrb), 256'(w_q[0].wstrb));
            checkOutput("wlast", 256'(w_if.wlast), 256'(w_q[0].wlast));
            void'(w_q.pop_front());
          end
        end
      end
      if (done) begin
        checkOutput("done_expected", 256'(pending_done > 0), 256'(1));
        if (pending_done > 0) pending_done--;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    hdr_valid = 1'b0; hdr_addr = '0; hdr_length = '0; hdr_bdf = '0; hdr_is_memwrite = 1'b0;
    data_valid = 1'b0; data = '0;
    bvalid = 1'b0; bresp = 2'b00; bid = '0;
    aw_if.aready = 1'b0; w_if.wready = 1'b0;
    #1;
    checkOutput("reset_avalid", 256'(aw_if.avalid), 256'(0));
    checkOutput("reset_wvalid", 256'(w_if.wvalid), 256'(0));
    checkOutput("reset_done", 256'(done), 256'(0));
    checkOutput("reset_err_cnt", 256'(err_cnt), 256'(0));
    checkOutput("reset_hdr_ready", 256'(hdr_ready), 256'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_hdr_ready", 256'(hdr_ready), 256'(1));
    checkOutput("idle_data_ready", 256'(data_ready), 256'(0));
    @(posedge clk); #1;

    //            tag addr           len    wr  awaddr         beats last_strb      resp   wpat     dly rst
    applyStimulus(1, 32'h1000_0020, 10'd8,  1, 32'h1000_0020, 1, 32'hFFFF_FFFF, 2'b00, 4'b1111, 0, -1);
    applyStimulus(2, 32'h2000_0047, 10'd20, 1, 32'h2000_0040, 3, 32'h0000_FFFF, 2'b00, 4'b1111, 2, -1);
    applyStimulus(3, 32'h3000_0100, 10'd32, 1, 32'h3000_0100, 4, 32'hFFFF_FFFF, 2'b00, 4'b1001, 0, -1);
    applyStimulus(4, 32'h0000_001F, 10'd1,  1, 32'h0000_0000, 1, 32'h0000_000F, 2'b00, 4'b1111, 1, -1);
    applyStimulus(5, 32'h4000_0060, 10'd13, 1, 32'h4000_0060, 2, 32'h000F_FFFF, 2'b10, 4'b1111, 0, -1);
    applyStimulus(6, 32'h5000_0000, 10'd8,  0, 32'h0,         0, 32'h0,         2'b00, 4'b1111, 0, -1);
    applyStimulus(7, 32'h5000_0000, 10'd0,  1, 32'h0,         0, 32'h0,         2'b00, 4'b1111, 0, -1);
    applyStimulus(8, 32'h5000_0000, 10'd40, 1, 32'h0,         0, 32'h0,         2'b00, 4'b1111, 0, -1);
    applyStimulus(9, 32'h5000_0000, 10'd33, 1, 32'h0,         0, 32'h0,         2'b00, 4'b1111, 0, -1);

    // A response arriving while idle must be refused and must not complete anything.
    bvalid = 1'b1; bresp = 2'b10;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stray_bready", 256'(bready), 256'(0));
    end
    @(posedge clk); #1;
    bvalid = 1'b0; bresp = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stray_err_cnt", 256'(err_cnt), 256'(exp_err));

    applyStimulus(10, 32'h5000_0000, 10'd32, 1, 32'h5000_0000, 4, 32'hFFFF_FFFF, 2'b00, 4'b1111, 0, 2);
    applyStimulus(11, 32'h6000_0020, 10'd9,  1, 32'h6000_0020, 2, 32'h0000_000F, 2'b00, 4'b1111, 0, -1);

    // Back-to-back dropped headers drive the error counter into saturation.
    hdr_is_memwrite = 1'b0; hdr_length = 10'd8; hdr_valid = 1'b1;
    repeat (254) @(posedge clk);
    #1;
    hdr_valid = 1'b0;
    @(negedge clk);
    checkOutput("err_cnt_254", 256'(err_cnt), 256'(254));
    @(posedge clk); #1;
    hdr_valid = 1'b1;
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    @(negedge clk);
    checkOutput("err_cnt_255", 256'(err_cnt), 256'(255));
    @(posedge clk); #1;
    hdr_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    hdr_valid = 1'b0;
    @(negedge clk);
    checkOutput("err_cnt_saturated", 256'(err_cnt), 256'(255));

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
